seq_exec: RTL
=============

Name: seq_exec

Overview:
Sequencer execution controller that sits directly upstream of the sequencer ALU. It accepts 8-bit instructions over a valid/ready handshake and holds a small register file. For push/add/mult it issues the operands, op and immediate to the ALU, waits for the ALU result and writes it back. For send it presents a register value on a transmit handshake.

Parameters:
ALU_W, 8, datapath / register width (matches ALU width)
OP_W, 2, opcode width
IM_W, 4, immediate width (push constant)
NREG, 4, number of registers
RA_W, 2, register index width (log2 NREG)

Ports:
clk  in  1  system clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
i_inst  in  8  instruction: [7:6] op, [5:4] ra (dest/first src), [3:2] rb (second src), [3:0] imm (push only)
i_inst_valid  in  1  instruction present
o_inst_ready  out  1  controller can accept instruction
o_alu_a  out  ALU_W  operand A = reg[ra]
o_alu_b  out  ALU_W  operand B = reg[rb]
o_alu_op  out  OP_W  op code to ALU
o_alu_const  out  IM_W  immediate to ALU
o_alu_valid  out  1  one-cycle issue strobe to ALU
i_alu_data  in  ALU_W  ALU result
i_alu_valid  in  1  ALU result valid
o_tx_data  out  ALU_W  send value
o_tx_valid  out  1  send value present
i_tx_ready  in  1  consumer accepts send value
o_busy  out  1  state != IDLE

Behaviour:
- Opcodes: 00 push, 01 add, 10 mult, 11 send.
- Reset (async assert, sync release):
  - state=IDLE; all NREG registers=0; instruction latch=0.
  - o_alu_valid=0, o_tx_valid=0, o_tx_data=0, o_busy=0, o_inst_ready=1.
  - Reset mid-operation abandons the instruction: no write-back, no tx.
- States: IDLE, ISSUE, WAIT, SEND.
- IDLE:
  - o_inst_ready=1.
  - On i_inst_valid&o_inst_ready: latch i_inst; next state is SEND if op==11, else ISSUE.
  - i_alu_valid is ignored in IDLE.
- ISSUE:
  - o_alu_valid=1 for exactly this cycle.
  - o_alu_a/b/op/const driven from the latched instruction and the current reg[ra]/reg[rb].
  - If i_alu_valid=1 in the same cycle (combinational ALU): reg[ra]<=i_alu_data at this edge, then IDLE.
  - Else go to WAIT.
- WAIT:
  - o_alu_valid=0; operands, op and const held stable.
  - On the first i_alu_valid: reg[ra]<=i_alu_data, then IDLE.
  - No timeout.
- SEND:
  - o_tx_valid=1, o_tx_data=reg[ra], held stable until i_tx_ready.
  - Transfer completes on the cycle o_tx_valid&i_tx_ready; then IDLE. No register changes.
- o_inst_ready=0 in ISSUE/WAIT/SEND; o_busy=1 in those states.
- Latency (combinational ALU):
  - Instruction accepted at edge N; result visible in reg at edge N+1.
  - Next instruction accepted at edge N+2, so the peak rate is 1 instruction per 2 cycles.
- Arithmetic is done in the ALU: push = {reg,imm} truncated to ALU_W; add/mult truncated mod 2^ALU_W. This block only writes back i_alu_data.
- ra==rb is legal; both operands read the same pre-write value.
- o_alu_* outputs are don't-care outside ISSUE/WAIT, but must not glitch o_alu_valid.

Test Plan:
- Reset: assert rst mid-WAIT -> all regs read 0, o_inst_ready=1, o_alu_valid=0, o_tx_valid=0 immediately (async).
- Push chain: push r0 imm=0x3, then push r0 imm=0x5 (model ALU) -> r0=0x35; send r0 -> o_tx_data=0x35 held until i_tx_ready.
- Add wrap: r1=0xF0, r2=0x20; add r1,r2 -> r1=0x10. Check o_alu_valid pulses exactly 1 cycle and next inst accepted 2 cycles after previous.
- Mult via 3-cycle-latency ALU model: r0=0x07, r3=0x06; mult r0,r3 -> operands stay stable through WAIT, r0=0x2A. Stray i_alu_valid pulse injected while IDLE -> no register change.
- Send backpressure: send r2 with i_tx_ready low 5 cycles -> o_tx_valid/o_tx_data stable, o_inst_ready=0. Ready high -> IDLE next cycle; a queued i_inst_valid is then accepted.
- Self-op: r1=0x09; add r1,r1 -> r1=0x12; mult r1,r1 -> r1=0x44 (0x144 truncated).

Source files
------------

// File: rtl/seq_exec.sv
// Sequencer execution controller: accepts 8-bit instructions, issues push/add/mult
// to the downstream ALU with result write-back, and presents register values on a tx handshake.
module seq_exec #(
   parameter int ALU_W = 8,
   parameter int OP_W  = 2,
   parameter int IM_W  = 4,
   parameter int NREG  = 4,
   parameter int RA_W  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       i_inst,
   input  logic             i_inst_valid,
   output logic             o_inst_ready,
   output logic [ALU_W-1:0] o_alu_a,
   output logic [ALU_W-1:0] o_alu_b,
   output logic [OP_W-1:0]  o_alu_op,
   output logic [IM_W-1:0]  o_alu_const,
   output logic             o_alu_valid,
   input  logic [ALU_W-1:0] i_alu_data,
   input  logic             i_alu_valid,
   output logic [ALU_W-1:0] o_tx_data,
   output logic             o_tx_valid,
   input  logic             i_tx_ready,
   output logic             o_busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_SEND  = 2'd3
   } state_t;

   localparam logic [OP_W-1:0] OP_SEND = '1;

   state_t            r_state;
   logic [7:0]        r_inst;
   logic [ALU_W-1:0]  r_regs [NREG];
   logic              r_alu_valid;
   logic              r_tx_valid;
   logic [ALU_W-1:0]  r_tx_data;
   logic              r_inst_ready;
   logic              r_busy;

   logic [OP_W-1:0]   w_op;
   logic [RA_W-1:0]   w_ra;
   logic [RA_W-1:0]   w_rb;
   logic [OP_W-1:0]   w_in_op;
   logic [RA_W-1:0]   w_in_ra;
   logic              w_accept;
   logic              w_wb;

   assign w_op     = r_inst[7 -: OP_W];
   assign w_ra     = r_inst[4 +: RA_W];
   assign w_rb     = r_inst[2 +: RA_W];
   assign w_in_op  = i_inst[7 -: OP_W];
   assign w_in_ra  = i_inst[4 +: RA_W];
   assign w_accept = r_inst_ready & i_inst_valid;
   // Result is only taken while an ALU op is outstanding; stray valids in IDLE/SEND are dropped
   assign w_wb     = ((r_state == S_ISSUE) || (r_state == S_WAIT)) && i_alu_valid;

   generate
      for (genvar gi = 0; gi < NREG; gi++) begin : g_regs
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_regs[gi] <= '0;
            end else if (w_wb && (w_ra == RA_W'(gi))) begin
               r_regs[gi] <= i_alu_data;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_inst       <= '0;
         r_alu_valid  <= 1'b0;
         r_tx_valid   <= 1'b0;
         r_tx_data    <= '0;
         r_inst_ready <= 1'b1;
         r_busy       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_inst       <= i_inst;
                  r_inst_ready <= 1'b0;
                  r_busy       <= 1'b1;
                  if (w_in_op == OP_SEND) begin
                     r_state    <= S_SEND;
                     r_tx_valid <= 1'b1;
                     r_tx_data  <= r_regs[w_in_ra];
                  end else begin
                     r_state     <= S_ISSUE;
                     r_alu_valid <= 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               r_alu_valid <= 1'b0;
               if (i_alu_valid) begin
                  r_state      <= S_IDLE;
                  r_inst_ready <= 1'b1;
                  r_busy       <= 1'b0;
               end else begin
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (i_alu_valid) begin
                  r_state      <= S_IDLE;
                  r_inst_ready <= 1'b1;
                  r_busy       <= 1'b0;
               end
            end
            S_SEND: begin
               if (i_tx_ready) begin
                  r_state      <= S_IDLE;
                  r_tx_valid   <= 1'b0;
                  r_inst_ready <= 1'b1;
                  r_busy       <= 1'b0;
               end
            end
            default: begin
               r_state      <= S_IDLE;
               r_alu_valid  <= 1'b0;
               r_tx_valid   <= 1'b0;
               r_inst_ready <= 1'b1;
               r_busy       <= 1'b0;
            end
         endcase
      end
   end

   // Operands follow the latched instruction; registers cannot change until write-back
   assign o_alu_a      = r_regs[w_ra];
   assign o_alu_b      = r_regs[w_rb];
   assign o_alu_op     = w_op;
   assign o_alu_const  = r_inst[IM_W-1:0];
   assign o_alu_valid  = r_alu_valid;
   assign o_tx_data    = r_tx_data;
   assign o_tx_valid   = r_tx_valid;
   assign o_inst_ready = r_inst_ready;
   assign o_busy       = r_busy;

endmodule
